// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider, signed/unsigned, fixed LENGTH+2 cycle latency.
// Optional early-out for zero divisor or |dividend| < |divisor|: define DIV_EARLY_OUT_EN.
module div_unit #(
    parameter int unsigned LENGTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [LENGTH-1:0] i_dividend,
    input  logic [LENGTH-1:0] i_divisor,
    input  logic              i_cancel,
    output logic              o_busy,
    output logic              o_done,
    output logic [LENGTH-1:0] o_quotient,
    output logic [LENGTH-1:0] o_remainder
);

    localparam int unsigned CntW = $clog2(LENGTH + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LENGTH:0]   rem_q, rem_d;
    // Holds the dividend magnitude, shifted out MSB-first as quotient bits shift in.
    logic [LENGTH-1:0] quo_q, quo_d;
    logic [LENGTH-1:0] dvs_q, dvs_d;
    logic [LENGTH-1:0] dvd_raw_q, dvd_raw_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              dvs_zero_q, dvs_zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LENGTH-1:0] quot_out_q, quot_out_d;
    logic [LENGTH-1:0] rem_out_q, rem_out_d;

    logic              dvd_neg, dvs_neg;
    logic [LENGTH-1:0] dvd_mag, dvs_mag;
    logic [LENGTH:0]   shifted, diff, rem_next;
    logic              step_ok;
    logic [LENGTH-1:0] quo_next, q_fix, r_fix;
    logic              early;

    assign dvd_neg = i_signed & i_dividend[LENGTH-1];
    assign dvs_neg = i_signed & i_divisor[LENGTH-1];
    assign dvd_mag = dvd_neg ? -i_dividend : i_dividend;
    assign dvs_mag = dvs_neg ? -i_divisor : i_divisor;

    assign shifted  = {rem_q[LENGTH-1:0], quo_q[LENGTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_ok  = ~diff[LENGTH];
    assign rem_next = step_ok ? diff : shifted;
    assign quo_next = {quo_q[LENGTH-2:0], step_ok};
    assign q_fix    = q_neg_q ? -quo_next : quo_next;
    assign r_fix    = r_neg_q ? -rem_next[LENGTH-1:0] : rem_next[LENGTH-1:0];

`ifdef DIV_EARLY_OUT_EN
    // Only valid on the first CALC cycle, before quo_q starts shifting.
    assign early = (cnt_q == CntW'(LENGTH)) && (dvs_zero_q || (quo_q < dvs_q));
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dvd_raw_d  = dvd_raw_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dvs_zero_d = dvs_zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;

        case (state_q)
            StIdle: begin
                if (i_start && !i_cancel) begin
                    dvd_raw_d  = i_dividend;
                    quo_d      = dvd_mag;
                    dvs_d      = dvs_mag;
                    rem_d      = '0;
                    q_neg_d    = dvd_neg ^ dvs_neg;
                    r_neg_d    = dvd_neg;
                    dvs_zero_d = (i_divisor == '0);
                    cnt_d      = CntW'(LENGTH);
                    busy_d     = 1'b1;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                if (i_cancel) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (early) begin
                    state_d    = StDone;
                    done_d     = 1'b1;
                    quot_out_d = dvs_zero_q ? '1 : '0;
                    rem_out_d  = dvd_raw_q;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q - 1'b1;
                    // Results are registered on entry to DONE so they are valid with o_done.
                    if (cnt_q == CntW'(1)) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        quot_out_d = dvs_zero_q ? '1 : q_fix;
                        rem_out_d  = dvs_zero_q ? dvd_raw_q : r_fix;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dvd_raw_q  <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dvs_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dvd_raw_q  <= dvd_raw_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dvs_zero_q <= dvs_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_quotient  = quot_out_q;
    assign o_remainder = rem_out_q;

endmodule
